// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Cyclic-priority arbiter: grants the first requester found when searching
// upward from ptr, wrapping from N_CH-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt
);

    // Walk the channels in priority order starting at ptr; first request wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        logic             found;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = SEL_W'((int'(ptr) + i) % N_CH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration
// feeding a one-entry output register. The ready path depends only on grant
// and output occupancy, never on the data.
module stream_mux_rr #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import stream_mux_pkg::*;

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic [N_CH-1:0]  arb_gnt;
    logic [N_CH-1:0]  fix_gnt;
    logic [N_CH-1:0]  grant;
    logic             can_load;
    logic             xfer;
    logic [SEL_W-1:0] xfer_ch;
    logic [WIDTH-1:0] xfer_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Fixed-mode grant: one-hot at sel, all zero when sel names no channel.
    always_comb begin
        fix_gnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i) fix_gnt[i] = 1'b1;
        end
    end

    assign grant    = (mode == MODE_RR) ? arb_gnt : fix_gnt;
    assign can_load = ~out_valid_q | out_ready;
    // rst_n gating keeps every ready low while the block is held in reset.
    assign in_ready = grant & {N_CH{can_load & rst_n}};
    assign xfer     = |(in_ready & in_valid);

    // Encode the granted channel and pick its data for loading.
    always_comb begin
        xfer_ch   = '0;
        xfer_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                xfer_ch   = SEL_W'(i);
                xfer_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = xfer_data;
            out_ch_d    = xfer_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer && (mode == MODE_RR)) begin
            rr_ptr_d = (int'(xfer_ch) == N_CH - 1) ? '0 : xfer_ch + SEL_W'(1);
        end
    end

    // State registers; reset discards any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
